// File: rtl/wb_arb_pkg.sv
// Shared widths and arbiter state encoding for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int unsigned WB_AW = 5;
    localparam int unsigned WB_DW = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO buffering long-latency unit results until they win the write port.
module wb_result_fifo #(
    parameter int unsigned W     = 37,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         last
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign last  = (count == CW'(1));
    assign dout  = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and buffered
// long-latency unit results, stalling the pipeline when a unit result starves.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned DW           = WB_DW,
    parameter int unsigned AW           = WB_AW,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_wr_en,
    input  logic [AW-1:0] pipe_wr_addr,
    input  logic [DW-1:0] pipe_wr_data,
    input  logic          lu_valid,
    output logic          lu_ready,
    input  logic [AW-1:0] lu_addr,
    input  logic [DW-1:0] lu_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          pipe_stall,
    output logic          lu_pending
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e       state;
    logic [SW-1:0]    starve_cnt;
    logic [AW+DW-1:0] head;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_last;
    logic             do_push;
    logic             pop;
    logic             pipe_req;
    logic             head_blocked;

    assign lu_ready   = !rst && !fifo_full;
    assign lu_pending = !fifo_empty;
    assign do_push    = lu_valid && lu_ready;
    assign pipe_req   = pipe_wr_en && (pipe_wr_addr != '0);
    assign head_addr  = head[DW +: AW];
    assign head_data  = head[DW-1:0];

    wb_result_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .din   ({lu_addr, lu_data}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .last  (fifo_last)
    );

    // Zero-latency write-port mux; a head addressed to $0 is popped without writing.
    always_comb begin
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        pop          = 1'b0;
        head_blocked = 1'b0;
        if (!rst) begin
            if (state == NORMAL && pipe_req) begin
                rf_we        = 1'b1;
                rf_waddr     = pipe_wr_addr;
                rf_wdata     = pipe_wr_data;
                head_blocked = !fifo_empty;
            end else if (!fifo_empty) begin
                pop      = 1'b1;
                rf_we    = (head_addr != '0);
                rf_waddr = head_addr;
                rf_wdata = head_data;
            end
        end
    end

    // Starvation tracking and NORMAL/FORCE state; pipe_stall mirrors the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORMAL;
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            if (pop || fifo_empty) begin
                starve_cnt <= '0;
            end else if (head_blocked && starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
            case (state)
                NORMAL: begin
                    if (head_blocked && starve_cnt == SW'(STARVE_LIMIT - 1)) begin
                        state      <= FORCE;
                        pipe_stall <= 1'b1;
                    end
                end
                FORCE: begin
                    if (fifo_empty || (pop && fifo_last && !do_push)) begin
                        state      <= NORMAL;
                        pipe_stall <= 1'b0;
                    end
                end
                default: begin
                    state      <= NORMAL;
                    pipe_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected register-file writes are queued as
// stimulus is driven and retired by a monitor whenever rf_we is seen.
module tb_wb_port_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_wr_en;
    logic [AW-1:0] pipe_wr_addr;
    logic [DW-1:0] pipe_wr_data;
    logic          lu_valid;
    logic          lu_ready;
    logic [AW-1:0] lu_addr;
    logic [DW-1:0] lu_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          pipe_stall;
    logic          lu_pending;

    int  n_checks = 0;
    int  n_errors = 0;
    wr_t sb[$];

    wb_port_arbiter #(
        .DW           (DW),
        .AW           (AW),
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wr_en   (pipe_wr_en),
        .pipe_wr_addr (pipe_wr_addr),
        .pipe_wr_data (pipe_wr_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_addr      (lu_addr),
        .lu_data      (lu_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pipe_stall   (pipe_stall),
        .lu_pending   (lu_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb.push_back(w);
    endtask

    task automatic drive_pipe(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pipe_wr_en   = en;
        pipe_wr_addr = a;
        pipe_wr_data = d;
    endtask

    task automatic drive_lu(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        lu_valid = v;
        lu_addr  = a;
        lu_data  = d;
    endtask

    // Monitor: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_wr", 64'(rf_we), 64'd0);
            end else begin
                wr_t w;
                w = sb.pop_front();
                check("wr_addr", 64'(rf_waddr), 64'(w.addr));
                check("wr_data", 64'(rf_wdata), 64'(w.data));
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive_pipe(1'b0, '0, '0);
        drive_lu(1'b0, '0, '0);

        // Reset state
        step();
        step();
        @(negedge clk);
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_lu_ready", 64'(lu_ready), 64'd0);
        check("rst_stall", 64'(pipe_stall), 64'd0);
        check("rst_pending", 64'(lu_pending), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(lu_ready), 64'd1);

        // Pipe-only write, same-cycle
        step();
        drive_pipe(1'b1, 5'd5, 32'hA5);
        expect_wr(5'd5, 32'hA5);
        @(negedge clk);
        check("pipe_only_we", 64'(rf_we), 64'd1);
        step();
        drive_pipe(1'b0, '0, '0);

        // Idle pipe: unit result granted the cycle after the push, no bypass
        drive_lu(1'b1, 5'd7, 32'h1234);
        @(negedge clk);
        check("no_bypass_we", 64'(rf_we), 64'd0);
        step();
        drive_lu(1'b0, '0, '0);
        expect_wr(5'd7, 32'h1234);
        @(negedge clk);
        check("lu_grant_pending", 64'(lu_pending), 64'd1);
        step();
        @(negedge clk);
        check("lu_drained", 64'(lu_pending), 64'd0);

        // $0 filtering: pipe addr 0 yields to head; head addr 0 is dropped
        step();
        drive_pipe(1'b1, 5'd9, 32'h99);
        expect_wr(5'd9, 32'h99);
        drive_lu(1'b1, 5'd3, 32'h33);
        step();
        drive_lu(1'b0, '0, '0);
        drive_pipe(1'b1, 5'd0, 32'hFFFF);
        expect_wr(5'd3, 32'h33);
        step();
        drive_pipe(1'b1, 5'd10, 32'hAA);
        expect_wr(5'd10, 32'hAA);
        drive_lu(1'b1, 5'd0, 32'hDEAD);
        step();
        drive_pipe(1'b0, '0, '0);
        drive_lu(1'b0, '0, '0);
        @(negedge clk);
        check("zero_head_we", 64'(rf_we), 64'd0);
        check("zero_head_pending", 64'(lu_pending), 64'd1);
        step();
        @(negedge clk);
        check("zero_head_popped", 64'(lu_pending), 64'd0);

        // Starvation: four blocked cycles, then one forced drain cycle
        step();
        for (int i = 0; i < 5; i++) begin
            drive_pipe(1'b1, 5'(i + 1), 32'h100 + 32'(i));
            expect_wr(5'(i + 1), 32'h100 + 32'(i));
            if (i == 0) drive_lu(1'b1, 5'd12, 32'hC0DE);
            @(negedge clk);
            check($sformatf("starve_stall_c%0d", i), 64'(pipe_stall), 64'd0);
            step();
            drive_lu(1'b0, '0, '0);
        end
        drive_pipe(1'b1, 5'd6, 32'h105);
        expect_wr(5'd12, 32'hC0DE);
        @(negedge clk);
        check("force_stall", 64'(pipe_stall), 64'd1);
        step();
        expect_wr(5'd6, 32'h105);
        @(negedge clk);
        check("force_exit_stall", 64'(pipe_stall), 64'd0);
        check("force_exit_pending", 64'(lu_pending), 64'd0);
        step();
        drive_pipe(1'b0, '0, '0);

        // Full FIFO, refused push, then push+pop at count 1
        drive_pipe(1'b1, 5'd20, 32'h200);
        expect_wr(5'd20, 32'h200);
        drive_lu(1'b1, 5'd14, 32'hE0);
        step();
        drive_pipe(1'b1, 5'd21, 32'h201);
        expect_wr(5'd21, 32'h201);
        drive_lu(1'b1, 5'd15, 32'hF0);
        @(negedge clk);
        check("full_ready_c1", 64'(lu_ready), 64'd1);
        step();
        drive_pipe(1'b1, 5'd22, 32'h202);
        expect_wr(5'd22, 32'h202);
        drive_lu(1'b1, 5'd23, 32'hBAD);
        @(negedge clk);
        check("full_ready_0", 64'(lu_ready), 64'd0);
        check("full_pending", 64'(lu_pending), 64'd1);
        step();
        drive_pipe(1'b0, '0, '0);
        drive_lu(1'b0, '0, '0);
        expect_wr(5'd14, 32'hE0);
        @(negedge clk);
        check("full_pop_ready", 64'(lu_ready), 64'd0);
        step();
        drive_lu(1'b1, 5'd16, 32'h160);
        expect_wr(5'd15, 32'hF0);
        @(negedge clk);
        check("pushpop_ready", 64'(lu_ready), 64'd1);
        step();
        drive_lu(1'b0, '0, '0);
        expect_wr(5'd16, 32'h160);
        @(negedge clk);
        check("pushpop_kept", 64'(lu_pending), 64'd1);
        check("pushpop_ready2", 64'(lu_ready), 64'd1);
        step();
        @(negedge clk);
        check("pushpop_drained", 64'(lu_pending), 64'd0);

        // Reset while in FORCE with buffered results
        step();
        for (int i = 0; i < 5; i++) begin
            drive_pipe(1'b1, 5'(i + 24), 32'h300 + 32'(i));
            expect_wr(5'(i + 24), 32'h300 + 32'(i));
            if (i == 0) drive_lu(1'b1, 5'd17, 32'h170);
            else if (i == 1) drive_lu(1'b1, 5'd18, 32'h180);
            else drive_lu(1'b0, '0, '0);
            step();
        end
        drive_lu(1'b0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stall_before", 64'(pipe_stall), 64'd1);
        check("midrst_we", 64'(rf_we), 64'd0);
        check("midrst_ready", 64'(lu_ready), 64'd0);
        step();
        rst = 1'b0;
        drive_pipe(1'b0, '0, '0);
        @(negedge clk);
        check("after_rst_stall", 64'(pipe_stall), 64'd0);
        check("after_rst_pending", 64'(lu_pending), 64'd0);
        check("after_rst_ready", 64'(lu_ready), 64'd1);
        step();
        step();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
